// File: rtl/timer_pkg.sv
// Shared constants and helpers for the microwave timer clock-divider path.
package timer_pkg;

  localparam int DEFAULT_DIVISOR = 100;

  // Counter width for a modulus, never narrower than one bit.
  function automatic int cnt_width(input int half);
    return (half > 1) ? $clog2(half) : 1;
  endfunction

endpackage

// File: rtl/freq_divide_by_100_mod_counter.sv
// Free-running modulo-MODULUS counter with a wrap flag on the terminal count.
module mod_counter
  import timer_pkg::*;
#(
  parameter  int MODULUS = 50,
  localparam int W       = cnt_width(MODULUS)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         wrap;

  always_comb begin
    count_d = count_q + ONE;
    wrap    = (count_q == LAST);
    if (wrap) begin
      count_d = '0;
    end else begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = wrap;

endmodule

// File: rtl/freq_divide_by_100.sv
// Divide-by-DIVISOR 50 %-duty clock divider (100 Hz -> 1 Hz by default).
// Optional registered out_tick pulse on each rising out_clock edge: define FREQ_DIV_TICK_EN.
// in_reset_n has no internal pull-up; an instantiating wrapper must tie it high when unused.
module freq_divide_by_100
  import timer_pkg::*;
#(
  parameter int DIVISOR = DEFAULT_DIVISOR
) (
  input  logic in_clock,
  output logic out_clock,
  input  logic in_reset_n
`ifdef FREQ_DIV_TICK_EN
  ,
  output logic out_tick
`endif
);

  localparam int HALF = DIVISOR / 2;
  localparam int CW   = cnt_width(HALF);
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  if ((DIVISOR < 2) || ((DIVISOR % 2) != 0)) begin : g_bad_divisor
    $error("freq_divide_by_100: DIVISOR must be even and >= 2");
  end

  logic [1:0]    sync_q;
  logic          rst_sync_n;
  logic [CW-1:0] count;
  logic          wrap;
  logic          toggle;
  logic          out_clk_q;
  logic          out_clk_d;

  // Assertion clears at once; release reaches the counter on the 2nd edge, so the first count is on the 3rd.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_sync_n = sync_q[1];

  mod_counter #(
    .MODULUS(HALF)
  ) u_counter (
    .clk_i  (in_clock),
    .rst_ni (rst_sync_n),
    .count_o(count),
    .wrap_o (wrap)
  );

  // Cross-check the wrap flag against the count it was derived from.
  always_comb begin
    toggle    = wrap && (count == LAST);
    out_clk_d = out_clk_q;
    if (toggle) begin
      out_clk_d = ~out_clk_q;
    end else begin
      out_clk_d = out_clk_q;
    end
  end

  always_ff @(posedge in_clock or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      out_clk_q <= 1'b0;
    end else begin
      out_clk_q <= out_clk_d;
    end
  end

  assign out_clock = out_clk_q;

`ifdef FREQ_DIV_TICK_EN
  logic tick_q;
  logic tick_d;

  always_comb begin
    tick_d = 1'b0;
    if (toggle && !out_clk_q) begin
      tick_d = 1'b1;
    end else begin
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge in_clock or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign out_tick = tick_q;
`endif

endmodule

// File: tb/tb_freq_divide_by_100.sv
// Directed bench for freq_divide_by_100 with DIVISOR = 100, 4 and 2.
module tb_freq_divide_by_100;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic out100, out4, out2;
`ifdef FREQ_DIV_TICK_EN
  logic tick100, tick4, tick2;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic exp4;
    logic exp2;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  freq_divide_by_100 #(.DIVISOR(100)) dut_d100 (
    .in_clock  (clk),
    .out_clock (out100),
    .in_reset_n(rst_n)
`ifdef FREQ_DIV_TICK_EN
    , .out_tick(tick100)
`endif
  );

  freq_divide_by_100 #(.DIVISOR(4)) dut_d4 (
    .in_clock  (clk),
    .out_clock (out4),
    .in_reset_n(rst_n)
`ifdef FREQ_DIV_TICK_EN
    , .out_tick(tick4)
`endif
  );

  freq_divide_by_100 #(.DIVISOR(2)) dut_d2 (
    .in_clock  (clk),
    .out_clock (out2),
    .in_reset_n(rst_n)
`ifdef FREQ_DIV_TICK_EN
    , .out_tick(tick2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One rising edge, then sample on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic prev;
    logic cur;
    logic stayed_low;
    int   rises;
    int   ticks;
    int   last_edge;

    // Edges after release: 1-2 synchronizer, then counted edges 1..6.
    tbl[0] = '{1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b0};

    #2 rst_n = 1'b0;
    repeat (3) step();
    check("reset_out100", {31'd0, out100}, 32'd0);
    check("reset_out4", {31'd0, out4}, 32'd0);
    check("reset_out2", {31'd0, out2}, 32'd0);
`ifdef FREQ_DIV_TICK_EN
    check("reset_tick100", {31'd0, tick100}, 32'd0);
`endif

    // Small divisors, table-driven from release.
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("div4_edge%0d", i + 1), {31'd0, out4}, {31'd0, tbl[i].exp4});
      check($sformatf("div2_edge%0d", i + 1), {31'd0, out2}, {31'd0, tbl[i].exp2});
    end

    // 1000 counted cycles on the default divider.
    rst_n = 1'b0;
    step();
    check("rerst_out100", {31'd0, out100}, 32'd0);
    rst_n = 1'b1;
    step();
    step();
    prev      = 1'b0;
    rises     = 0;
    ticks     = 0;
    last_edge = 0;
    for (int c = 1; c <= 1000; c++) begin
      step();
      cur = out100;
      if (cur !== prev) begin
        if (last_edge == 0) begin
          check("first_rise_edge", c, 32'd50);
        end else begin
          check($sformatf("phase_len_at%0d", c), c - last_edge, 32'd50);
        end
        last_edge = c;
        if (cur === 1'b1) begin
          rises++;
        end
      end
`ifdef FREQ_DIV_TICK_EN
      if (tick100 === 1'b1) begin
        ticks++;
        check($sformatf("tick_on_rise_at%0d", c), {30'd0, prev, cur}, 32'd1);
      end
`endif
      prev = cur;
    end
    check("rise_count", rises, 32'd10);
    check("final_level", {31'd0, out100}, 32'd0);
`ifdef FREQ_DIV_TICK_EN
    check("tick_count", ticks, 32'd10);
`endif

    // Reset at count 30 of a high phase.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    repeat (80) step();
    check("mid_high_level", {31'd0, out100}, 32'd1);
    check("mid_count30", 32'(dut_d100.u_counter.count_o), 32'd30);
    #2 rst_n = 1'b0;
    #1;
    check("async_clr_out", {31'd0, out100}, 32'd0);
    check("async_clr_count", 32'(dut_d100.u_counter.count_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    stayed_low = 1'b1;
    for (int c = 1; c < 50; c++) begin
      step();
      if (out100 !== 1'b0) begin
        stayed_low = 1'b0;
      end
    end
    check("restart_low_49", {31'd0, stayed_low}, 32'd1);
    step();
    check("restart_rise_50", {31'd0, out100}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
